// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
// Decodes PS/2 set-2 scan-code bytes into press/repeat/release events and
// tracks the keys that are currently held.
//
// Ports
//   clk           rising-edge clock for all state
//   rst           synchronous reset, active low
//   code_valid    one-cycle strobe: code_in carries a new byte
//   code_in       raw scan-code byte
//   press_count   count of new key presses, wraps modulo 2^CNT_W
//   last_code     {ext,code} of the most recent new press
//   held_num      number of occupied held-table entries
//   held_codes    held table, entry 0 (oldest press) in bits [8:0], unused = 0
//   hist          raw byte history, bits [7:0] = most recent byte
//   press_pulse   one cycle: new press decoded
//   repeat_pulse  one cycle: make code of a key that is already held
//   release_pulse one cycle: break code decoded
//   event_code    {ext,code} of the latest press/repeat/release
//   err_pulse     one cycle: protocol error
//   overflow      sticky: a press arrived while the held table was full
module ps2_key_tracker #(
    parameter int CNT_W      = 8,
    parameter int MAX_HELD   = 4,
    parameter int HIST_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            code_valid,
    input  logic [7:0]                      code_in,
    output logic [CNT_W-1:0]                press_count,
    output logic [8:0]                      last_code,
    output logic [$clog2(MAX_HELD+1)-1:0]   held_num,
    output logic [9*MAX_HELD-1:0]           held_codes,
    output logic [8*HIST_DEPTH-1:0]         hist,
    output logic                            press_pulse,
    output logic                            repeat_pulse,
    output logic                            release_pulse,
    output logic [8:0]                      event_code,
    output logic                            err_pulse,
    output logic                            overflow
);

    localparam int HW = $clog2(MAX_HELD + 1);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t state_reg, state_next;

    // Decoder outputs for the byte presented this cycle
    logic       is_make;
    logic       is_break;
    logic       dec_ext;
    logic       dec_err;
    logic [8:0] dec_code;

    logic [8:0]    held_reg   [MAX_HELD];
    logic [8:0]    shift_src  [MAX_HELD];
    logic [HW-1:0] held_num_reg;
    logic [7:0]    hist_reg   [HIST_DEPTH];
    logic [7:0]    hist_src   [HIST_DEPTH];

    logic          found;
    logic [HW-1:0] found_idx;
    logic          table_full;
    logic          do_insert;
    logic          do_remove;

    // ------------------------------------------------------------------
    // Decoder FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        is_make    = 1'b0;
        is_break   = 1'b0;
        dec_ext    = 1'b0;
        dec_err    = 1'b0;
        if (code_valid) begin
            if (code_in == 8'h00 || code_in == 8'hFF) begin
                // Line-level garbage aborts any sequence in progress
                dec_err    = 1'b1;
                state_next = IDLE;
            end else begin
                unique case (state_reg)
                    IDLE: begin
                        if (code_in == 8'hE0) begin
                            state_next = EXT;
                        end else if (code_in == 8'hF0) begin
                            state_next = BRK;
                        end else begin
                            is_make = 1'b1;
                        end
                    end
                    EXT: begin
                        if (code_in == 8'hF0) begin
                            state_next = EXT_BRK;
                        end else if (code_in == 8'hE0) begin
                            // Repeated E0 is tolerated silently
                            state_next = EXT;
                        end else begin
                            is_make    = 1'b1;
                            dec_ext    = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    BRK, EXT_BRK: begin
                        state_next = IDLE;
                        if (code_in == 8'hE0 || code_in == 8'hF0) begin
                            dec_err = 1'b1;
                        end else begin
                            is_break = 1'b1;
                            dec_ext  = (state_reg == EXT_BRK);
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    assign dec_code = {dec_ext, code_in};

    // ------------------------------------------------------------------
    // Held-table lookup (only occupied entries can match)
    // ------------------------------------------------------------------
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = 0; i < MAX_HELD; i++) begin
            if (!found && (HW'(i) < held_num_reg) && (held_reg[i] == dec_code)) begin
                found     = 1'b1;
                found_idx = HW'(i);
            end
        end
    end

    assign table_full = (held_num_reg == HW'(MAX_HELD));
    assign do_insert  = is_make && !found && !table_full;
    assign do_remove  = is_break && found;

    // Each entry's compaction source is its upper neighbour; the top entry
    // takes zero so vacated slots read back as 0.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_HELD; gi++) begin : g_held
            if (gi == MAX_HELD - 1) begin : g_top
                assign shift_src[gi] = 9'd0;
            end else begin : g_mid
                assign shift_src[gi] = held_reg[gi+1];
            end
            assign held_codes[9*gi +: 9] = held_reg[gi];
        end

        for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_src[gi] = code_in;
            end else begin : g_tail
                assign hist_src[gi] = hist_reg[gi-1];
            end
            assign hist[8*gi +: 8] = hist_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MAX_HELD; i++) begin
                held_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_HELD; i++) begin
                if (do_remove && (HW'(i) >= found_idx)) begin
                    held_reg[i] <= shift_src[i];
                end else if (do_insert && (HW'(i) == held_num_reg)) begin
                    held_reg[i] <= dec_code;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_reg[i] <= '0;
            end
        end else if (code_valid) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_reg[i] <= hist_src[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters, event outputs and pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            held_num_reg  <= '0;
            press_count   <= '0;
            last_code     <= '0;
            event_code    <= '0;
            overflow      <= 1'b0;
            press_pulse   <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            err_pulse     <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
            err_pulse     <= dec_err;
            if (is_make) begin
                event_code <= dec_code;
                if (found) begin
                    // Typematic repeat of a held key
                    repeat_pulse <= 1'b1;
                end else begin
                    press_pulse <= 1'b1;
                    press_count <= press_count + CNT_W'(1);
                    last_code   <= dec_code;
                    if (table_full) begin
                        overflow <= 1'b1;
                    end else begin
                        held_num_reg <= held_num_reg + HW'(1);
                    end
                end
            end
            if (is_break) begin
                event_code    <= dec_code;
                release_pulse <= 1'b1;
                if (found) begin
                    held_num_reg <= held_num_reg - HW'(1);
                end
            end
        end
    end

    assign held_num = held_num_reg;

endmodule
